cache_miss_ctrl: RTL and testbench
==================================

// Module: cache_miss_ctrl
// PURPOSE
//  Cache-side controller for one 2-way set-associative cache: accepts CPU lookups, checks tag hit,
//  picks a victim from the LRU way selector on miss, fetches a full line from memory, writes the line
//  and tag into the victim way, and drives the LRU update. Sits upstream of the LRU selector:
//  produces its index, hit vector and update strobe, and consumes its way_sel victim output.
// PARAMETERS
//  CACHE_WAY     2    number of ways (design fixed at 2; from CPU_Parameter.vh)
//  RAM_DEPTH_LOG 8    index bits = log2(sets) (from CPU_Parameter.vh)
//  OFFSET_LOG    2    log2(words per line); LINE_WORDS = 1<<OFFSET_LOG
//  ADDR_W        32   byte address width
//  DATA_W        32   word width
// PORTS
//  clk            in   1              clock, all state on rising edge
//  rst            in   1              asynchronous, active-high reset
//  req_valid      in   1              CPU lookup request
//  req_addr       in   ADDR_W         byte address {tag,index,offset,2'b00}
//  req_ready      out  1              request accepted when req_valid&req_ready
//  hit            in   CACHE_WAY      per-way tag-match result, valid in LOOKUP
//  way_sel        in   1              victim way index from LRU selector
//  lru_addr       out  RAM_DEPTH_LOG  set index to LRU selector
//  lru_hit        out  CACHE_WAY      one-hot way just used, to LRU hit input
//  lru_update     out  1              LRU update strobe
//  mem_rd_req     out  1              line read request to memory
//  mem_rd_addr    out  ADDR_W         line-aligned address (offset bits zero)
//  mem_rd_rdy     in   1              memory accepted request
//  mem_ret_valid  in   1              return beat valid
//  mem_ret_last   in   1              final beat of line
//  mem_ret_data   in   DATA_W         return word
//  refill_we      out  CACHE_WAY      one-hot data RAM word write enable
//  refill_index   out  RAM_DEPTH_LOG  set being written (= latched index)
//  refill_offset  out  OFFSET_LOG     word within line
//  refill_data    out  DATA_W         = mem_ret_data
//  tag_we         out  CACHE_WAY      one-hot tag+valid write enable
//  tag_wdata      out  ADDR_W-RAM_DEPTH_LOG-OFFSET_LOG-2  tag written with valid=1
//  resp_valid     out  1              one-cycle response pulse
//  resp_way       out  CACHE_WAY      one-hot way holding the requested word
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0 except req_ready=1; beat counter, victim, latched addr = 0.
//  - States IDLE, LOOKUP, MISS, REFILL, DONE. req_ready=1 only in IDLE; addr latched on accept.
//  - IDLE: accept -> LOOKUP next cycle (tag RAM read has 1-cycle latency).
//  - LOOKUP: |hit -> resp_valid=1, resp_way=hit, lru_hit=hit, lru_update=1, -> IDLE. Hit latency 1
//    cycle after accept. Multi-hit passed through unchanged (LRU holds). ~|hit -> latch
//    victim = way_sel ? 2'b10 : 2'b01, -> MISS.
//  - MISS: mem_rd_req=1, mem_rd_addr held stable until mem_rd_rdy; on rdy -> REFILL, counter=0.
//  - REFILL: each mem_ret_valid: refill_we=victim, refill_offset=counter, counter+1 (wraps mod
//    LINE_WORDS). mem_ret_valid&mem_ret_last -> DONE regardless of counter. No beat -> wait.
//  - DONE (1 cycle): tag_we=victim, lru_hit=victim, lru_update=1, resp_valid=1, resp_way=victim,
//    -> IDLE. Tag written only after full line, so a partially filled line is never valid.
//  - lru_addr = latched index in all states; lru_update never asserted outside LOOKUP-hit/DONE.
//  - Reset mid-MISS/REFILL: async return to IDLE, no tag write, no response; in-flight beats after
//    reset are ignored in IDLE. mem_ret_valid outside REFILL ignored.
//  - req_valid while busy: not accepted (req_ready=0); requester must hold.
// STRUCTURE
//  - CACHE_WAY, RAM_DEPTH_LOG, OFFSET_LOG, state encodings as `define in CPU_Parameter.vh.
//  - Single module; FSM + beat counter inline. LRU selector instantiated by parent, not here.
// TESTING
//  - Reset then req 0x0000_1040, hit=2'b01 -> resp_valid at cycle 2, resp_way=01, lru_update, lru_hit=01.
//  - Miss at 0x0000_2080, way_sel=1 -> mem_rd_addr=0x0000_2080, 4 beats D0..D3 -> refill_we=10,
//    offsets 0..3, then tag_we=10, tag_wdata=0x00002, resp_way=10, lru_hit=10.
//  - Miss with mem_rd_rdy delayed 5 cycles and 2 idle gaps between beats -> addr stable, offsets still 0..3.
//  - rst asserted after 2nd refill beat -> outputs to reset values next edge, no tag_we, req_ready=1.
//  - req_valid held during refill -> not accepted until IDLE; accepted cycle after DONE.

Source files
------------

// File: rtl/cache_miss_ctrl_pkg.sv
// Shared sizes, state encoding and address-field helpers for the 2-way cache miss controller.
package cache_miss_ctrl_pkg;

   localparam int unsigned CACHE_WAY     = 2;
   localparam int unsigned RAM_DEPTH_LOG = 8;
   localparam int unsigned OFFSET_LOG    = 2;
   localparam int unsigned ADDR_W        = 32;
   localparam int unsigned DATA_W        = 32;
   localparam int unsigned LINE_WORDS    = 1 << OFFSET_LOG;
   localparam int unsigned LOW_BITS      = OFFSET_LOG + 2;
   localparam int unsigned TAG_W         = ADDR_W - RAM_DEPTH_LOG - LOW_BITS;

   typedef enum logic [2:0] {
      StIdle,
      StLookup,
      StMiss,
      StRefill,
      StDone
   } state_e;

   function automatic logic [RAM_DEPTH_LOG-1:0] addr_index(input logic [ADDR_W-1:0] addr);
      return addr[LOW_BITS +: RAM_DEPTH_LOG];
   endfunction

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:LOW_BITS], {LOW_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/cache_miss_ctrl_if.sv
// Bundles the CPU, LRU-selector, memory and cache-RAM write signals of the miss controller.
interface cache_miss_ctrl_if;
   import cache_miss_ctrl_pkg::*;

   logic                     req_valid;
   logic [ADDR_W-1:0]        req_addr;
   logic                     req_ready;
   logic [CACHE_WAY-1:0]     hit;
   logic                     way_sel;
   logic [RAM_DEPTH_LOG-1:0] lru_addr;
   logic [CACHE_WAY-1:0]     lru_hit;
   logic                     lru_update;
   logic                     mem_rd_req;
   logic [ADDR_W-1:0]        mem_rd_addr;
   logic                     mem_rd_rdy;
   logic                     mem_ret_valid;
   logic                     mem_ret_last;
   logic [DATA_W-1:0]        mem_ret_data;
   logic [CACHE_WAY-1:0]     refill_we;
   logic [RAM_DEPTH_LOG-1:0] refill_index;
   logic [OFFSET_LOG-1:0]    refill_offset;
   logic [DATA_W-1:0]        refill_data;
   logic [CACHE_WAY-1:0]     tag_we;
   logic [TAG_W-1:0]         tag_wdata;
   logic                     resp_valid;
   logic [CACHE_WAY-1:0]     resp_way;

   modport master (
      input  req_valid, req_addr, hit, way_sel, mem_rd_rdy, mem_ret_valid, mem_ret_last,
             mem_ret_data,
      output req_ready, lru_addr, lru_hit, lru_update, mem_rd_req, mem_rd_addr, refill_we,
             refill_index, refill_offset, refill_data, tag_we, tag_wdata, resp_valid, resp_way
   );

   modport slave (
      output req_valid, req_addr, hit, way_sel, mem_rd_rdy, mem_ret_valid, mem_ret_last,
             mem_ret_data,
      input  req_ready, lru_addr, lru_hit, lru_update, mem_rd_req, mem_rd_addr, refill_we,
             refill_index, refill_offset, refill_data, tag_we, tag_wdata, resp_valid, resp_way
   );

endinterface

// File: rtl/cache_miss_ctrl.sv
// Lookup / miss / line-refill controller for a 2-way set-associative cache.
module cache_miss_ctrl
   import cache_miss_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   cache_miss_ctrl_if.master bus
);

   state_e                  state_q, state_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [CACHE_WAY-1:0]    victim_q, victim_d;
   logic [OFFSET_LOG-1:0]   cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         victim_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         victim_q <= victim_d;
         cnt_q    <= cnt_d;
      end
   end

   // addr_q only changes in IDLE, so every address derived from it is stable while busy.
   assign bus.lru_addr      = addr_index(addr_q);
   assign bus.refill_index  = addr_index(addr_q);
   assign bus.mem_rd_addr   = line_addr(addr_q);
   assign bus.tag_wdata     = addr_tag(addr_q);
   assign bus.refill_offset = cnt_q;
   assign bus.refill_data   = bus.mem_ret_data;

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      victim_d       = victim_q;
      cnt_d          = cnt_q;
      bus.req_ready  = 1'b0;
      bus.lru_hit    = '0;
      bus.lru_update = 1'b0;
      bus.mem_rd_req = 1'b0;
      bus.refill_we  = '0;
      bus.tag_we     = '0;
      bus.resp_valid = 1'b0;
      bus.resp_way   = '0;

      unique case (state_q)
         StIdle: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               state_d = StLookup;
            end
         end
         StLookup: begin
            if (|bus.hit) begin
               // Multi-hit is forwarded untouched; the LRU selector holds on it.
               bus.resp_valid = 1'b1;
               bus.resp_way   = bus.hit;
               bus.lru_hit    = bus.hit;
               bus.lru_update = 1'b1;
               state_d        = StIdle;
            end else begin
               victim_d = bus.way_sel ? 2'b10 : 2'b01;
               state_d  = StMiss;
            end
         end
         StMiss: begin
            bus.mem_rd_req = 1'b1;
            if (bus.mem_rd_rdy) begin
               cnt_d   = '0;
               state_d = StRefill;
            end
         end
         StRefill: begin
            if (bus.mem_ret_valid) begin
               bus.refill_we = victim_q;
               cnt_d         = cnt_q + OFFSET_LOG'(1);
               if (bus.mem_ret_last) state_d = StDone;
            end
         end
         StDone: begin
            // Tag goes valid only once the whole line is in the data RAM.
            bus.tag_we     = victim_q;
            bus.lru_hit    = victim_q;
            bus.lru_update = 1'b1;
            bus.resp_valid = 1'b1;
            bus.resp_way   = victim_q;
            state_d        = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl: hit, refills with stalls/gaps, mid-refill reset, busy hold.
module tb_cache_miss_ctrl;
   import cache_miss_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   cache_miss_ctrl_if bus ();

   cache_miss_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // Drive one request that misses; leaves the DUT in MISS at return (after the edge).
   task automatic issue_miss(input logic [31:0] addr, input logic ws);
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      bus.way_sel   = ws;
      tick();
      bus.req_valid = 1'b0;
      bus.hit       = 2'b00;
      settle();
      check("miss_lookup_no_resp", {31'd0, bus.resp_valid}, 32'd0);
      check("miss_lookup_no_lru", {31'd0, bus.lru_update}, 32'd0);
      tick();
   endtask

   initial begin
      bus.req_valid     = 1'b0;
      bus.req_addr      = '0;
      bus.hit           = '0;
      bus.way_sel       = 1'b0;
      bus.mem_rd_rdy    = 1'b0;
      bus.mem_ret_valid = 1'b0;
      bus.mem_ret_last  = 1'b0;
      bus.mem_ret_data  = '0;

      // Reset values
      settle();
      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      check("rst_lru_update", {31'd0, bus.lru_update}, 32'd0);
      check("rst_mem_rd_req", {31'd0, bus.mem_rd_req}, 32'd0);
      check("rst_refill_we", {30'd0, bus.refill_we}, 32'd0);
      check("rst_tag_we", {30'd0, bus.tag_we}, 32'd0);
      check("rst_lru_addr", {24'd0, bus.lru_addr}, 32'd0);
      check("rst_mem_rd_addr", bus.mem_rd_addr, 32'd0);
      tick();
      rst = 1'b0;

      // Hit at 0x1040: index 0x04, response one cycle after accept
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h0000_1040;
      settle();
      check("hit_accept_ready", {31'd0, bus.req_ready}, 32'd1);
      tick();
      bus.req_valid = 1'b0;
      bus.hit       = 2'b01;
      settle();
      check("hit_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      check("hit_resp_way", {30'd0, bus.resp_way}, 32'd1);
      check("hit_lru_update", {31'd0, bus.lru_update}, 32'd1);
      check("hit_lru_hit", {30'd0, bus.lru_hit}, 32'd1);
      check("hit_lru_addr", {24'd0, bus.lru_addr}, 32'h04);
      check("hit_busy_ready", {31'd0, bus.req_ready}, 32'd0);
      tick();
      bus.hit = 2'b00;
      settle();
      check("hit_back_idle", {31'd0, bus.req_ready}, 32'd1);
      check("hit_resp_pulse", {31'd0, bus.resp_valid}, 32'd0);

      // Miss at 0x2080, victim way 1, four back-to-back beats
      issue_miss(32'h0000_2080, 1'b1);
      bus.mem_rd_rdy = 1'b1;
      settle();
      check("m2_rd_req", {31'd0, bus.mem_rd_req}, 32'd1);
      check("m2_rd_addr", bus.mem_rd_addr, 32'h0000_2080);
      tick();
      bus.mem_rd_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.mem_ret_valid = 1'b1;
         bus.mem_ret_last  = (i == 3);
         bus.mem_ret_data  = 32'hD000_0000 + i;
         settle();
         check("m2_refill_we", {30'd0, bus.refill_we}, 32'h2);
         check("m2_refill_off", {30'd0, bus.refill_offset}, i);
         check("m2_refill_data", bus.refill_data, 32'hD000_0000 + i);
         check("m2_refill_idx", {24'd0, bus.refill_index}, 32'h08);
         check("m2_no_early_tag", {30'd0, bus.tag_we}, 32'd0);
         tick();
      end
      bus.mem_ret_valid = 1'b0;
      bus.mem_ret_last  = 1'b0;
      settle();
      check("m2_tag_we", {30'd0, bus.tag_we}, 32'h2);
      check("m2_tag_wdata", {12'd0, bus.tag_wdata}, 32'h0000_0002);
      check("m2_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      check("m2_resp_way", {30'd0, bus.resp_way}, 32'h2);
      check("m2_lru_hit", {30'd0, bus.lru_hit}, 32'h2);
      check("m2_lru_update", {31'd0, bus.lru_update}, 32'd1);
      tick();
      settle();
      check("m2_idle", {31'd0, bus.req_ready}, 32'd1);

      // Miss at 0x3a5c (nonzero offset), victim way 0, rdy after 5 cycles, gaps between beats
      issue_miss(32'h0000_3a5c, 1'b0);
      for (int c = 0; c < 5; c++) begin
         bus.mem_ret_valid = (c == 2);  // stray beat while waiting for rdy
         settle();
         check("m3_wait_rd_req", {31'd0, bus.mem_rd_req}, 32'd1);
         check("m3_wait_addr", bus.mem_rd_addr, 32'h0000_3a50);
         check("m3_stray_beat", {30'd0, bus.refill_we}, 32'd0);
         tick();
      end
      bus.mem_ret_valid = 1'b0;
      bus.mem_rd_rdy    = 1'b1;
      settle();
      check("m3_rdy_addr", bus.mem_rd_addr, 32'h0000_3a50);
      tick();
      bus.mem_rd_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < 2; g++) begin
            bus.mem_ret_valid = 1'b0;
            settle();
            check("m3_gap_we", {30'd0, bus.refill_we}, 32'd0);
            tick();
         end
         bus.mem_ret_valid = 1'b1;
         bus.mem_ret_last  = (i == 3);
         bus.mem_ret_data  = 32'hA5A5_0000 + i;
         settle();
         check("m3_refill_we", {30'd0, bus.refill_we}, 32'h1);
         check("m3_refill_off", {30'd0, bus.refill_offset}, i);
         check("m3_refill_idx", {24'd0, bus.refill_index}, 32'hA5);
         tick();
      end
      bus.mem_ret_valid = 1'b0;
      bus.mem_ret_last  = 1'b0;
      settle();
      check("m3_tag_we", {30'd0, bus.tag_we}, 32'h1);
      check("m3_tag_wdata", {12'd0, bus.tag_wdata}, 32'h0000_0003);
      check("m3_resp_way", {30'd0, bus.resp_way}, 32'h1);
      tick();

      // Reset after the second refill beat
      issue_miss(32'h0000_4100, 1'b1);
      bus.mem_rd_rdy = 1'b1;
      tick();
      bus.mem_rd_rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.mem_ret_valid = 1'b1;
         bus.mem_ret_data  = 32'hBEEF_0000 + i;
         tick();
      end
      rst = 1'b1;
      settle();
      check("rr_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rr_refill_we", {30'd0, bus.refill_we}, 32'd0);
      check("rr_tag_we", {30'd0, bus.tag_we}, 32'd0);
      check("rr_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      check("rr_lru_addr", {24'd0, bus.lru_addr}, 32'd0);
      check("rr_offset", {30'd0, bus.refill_offset}, 32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.mem_ret_last = (i == 1);
         settle();
         check("rr_late_beat_we", {30'd0, bus.refill_we}, 32'd0);
         check("rr_late_beat_tag", {30'd0, bus.tag_we}, 32'd0);
         check("rr_idle_ready", {31'd0, bus.req_ready}, 32'd1);
         tick();
      end
      bus.mem_ret_valid = 1'b0;
      bus.mem_ret_last  = 1'b0;

      // Request held while busy: accepted only the cycle after DONE
      issue_miss(32'h0000_5000, 1'b0);
      bus.req_valid  = 1'b1;
      bus.req_addr   = 32'h0000_6010;
      bus.mem_rd_rdy = 1'b1;
      settle();
      check("hold_miss_ready", {31'd0, bus.req_ready}, 32'd0);
      tick();
      bus.mem_rd_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.mem_ret_valid = 1'b1;
         bus.mem_ret_last  = (i == 3);
         settle();
         check("hold_refill_ready", {31'd0, bus.req_ready}, 32'd0);
         check("hold_lru_addr", {24'd0, bus.lru_addr}, 32'h00);
         tick();
      end
      bus.mem_ret_valid = 1'b0;
      bus.mem_ret_last  = 1'b0;
      settle();
      check("hold_done_ready", {31'd0, bus.req_ready}, 32'd0);
      check("hold_done_tag", {12'd0, bus.tag_wdata}, 32'h0000_0005);
      tick();
      settle();
      check("hold_accept_ready", {31'd0, bus.req_ready}, 32'd1);
      tick();
      bus.req_valid = 1'b0;
      bus.hit       = 2'b10;
      settle();
      check("hold_lookup_resp", {31'd0, bus.resp_valid}, 32'd1);
      check("hold_lookup_addr", {24'd0, bus.lru_addr}, 32'h01);
      check("hold_lookup_way", {30'd0, bus.resp_way}, 32'h2);
      tick();
      bus.hit = 2'b00;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
